// File: rtl/vga_timing_ctrl.sv
// ---------------------------------------------------------------------------
// vga_timing_ctrl
//   VGA raster sequencer. Owns the horizontal/vertical pixel counters and a
//   per-axis phase machine (active, front porch, sync, back porch). Produces
//   the sync pulses, the video-enable window, pixel coordinates and the
//   line/frame start strobes for the pixel-generation logic.
//
// Ports
//   clk         in   system clock, rising-edge
//   rst         in   synchronous active-high reset (wins over en)
//   en          in   pixel tick; the raster advances only when en=1
//   hsync       out  horizontal sync, active low
//   vsync       out  vertical sync, active low
//   video_on    out  position is inside the visible area
//   x, y        out  visible-area coordinates, 0 outside the visible area
//   line_start  out  one-clk pulse after the edge that loads h=0
//   frame_start out  one-clk pulse after the edge that loads (0,0)
//
// All outputs are registered: they are decoded from the next-state values
// and loaded on the same edge as the counters.
// ---------------------------------------------------------------------------
module vga_timing_ctrl #(
    parameter int N        = 11,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic         hsync,
    output logic         vsync,
    output logic         video_on,
    output logic [N-1:0] x,
    output logic [N-1:0] y,
    output logic         line_start,
    output logic         frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Counters must be able to hold TOTAL-1; refuse to elaborate otherwise.
    if (((H_TOTAL - 1) >= (2 ** N)) || ((V_TOTAL - 1) >= (2 ** N))) begin : g_size_check
        $error("vga_timing_ctrl: H_TOTAL-1 or V_TOTAL-1 does not fit in N bits");
    end

    localparam logic [N-1:0] ZERO         = {N{1'b0}};
    localparam logic [N-1:0] ONE          = {{(N-1){1'b0}}, 1'b1};
    localparam logic [N-1:0] H_FP_START   = N'(H_ACTIVE);
    localparam logic [N-1:0] H_SYNC_START = N'(H_ACTIVE + H_FP);
    localparam logic [N-1:0] H_BP_START   = N'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [N-1:0] H_LAST       = N'(H_TOTAL - 1);
    localparam logic [N-1:0] V_FP_START   = N'(V_ACTIVE);
    localparam logic [N-1:0] V_SYNC_START = N'(V_ACTIVE + V_FP);
    localparam logic [N-1:0] V_BP_START   = N'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [N-1:0] V_LAST       = N'(V_TOTAL - 1);

    typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} top_t;
    typedef enum logic [1:0] {HP_ACT = 2'd0, HP_FP = 2'd1, HP_SYNC = 2'd2, HP_BP = 2'd3} hphase_t;
    typedef enum logic [1:0] {VP_ACT = 2'd0, VP_FP = 2'd1, VP_SYNC = 2'd2, VP_BP = 2'd3} vphase_t;

    top_t         top_r,  top_s;
    hphase_t      hp_r,   hp_s;
    vphase_t      vp_r,   vp_s;
    logic [N-1:0] h_r,    h_s;
    logic [N-1:0] v_r,    v_s;
    logic         hsync_s, vsync_s, video_on_s, line_start_s, frame_start_s;
    logic [N-1:0] x_s, y_s;

    // Next-state: counter advance, phase transitions and output decode.
    always_comb begin
        top_s         = top_r;
        hp_s          = hp_r;
        vp_s          = vp_r;
        h_s           = h_r;
        v_s           = v_r;
        line_start_s  = 1'b0;
        frame_start_s = 1'b0;

        if (en) begin
            case (top_r)
                ST_IDLE: begin
                    // First tick loads (0,0) rather than advancing past it.
                    top_s         = ST_RUN;
                    h_s           = ZERO;
                    v_s           = ZERO;
                    hp_s          = HP_ACT;
                    vp_s          = VP_ACT;
                    line_start_s  = 1'b1;
                    frame_start_s = 1'b1;
                end
                ST_RUN: begin
                    if (h_r == H_LAST) begin
                        h_s = ZERO;
                        if (v_r == V_LAST) begin
                            v_s = ZERO;
                        end else begin
                            v_s = v_r + ONE;
                        end
                        // Vertical phase moves only on a line wrap.
                        case (vp_r)
                            VP_ACT:  if (v_s == V_FP_START)   vp_s = VP_FP;   else vp_s = VP_ACT;
                            VP_FP:   if (v_s == V_SYNC_START) vp_s = VP_SYNC; else vp_s = VP_FP;
                            VP_SYNC: if (v_s == V_BP_START)   vp_s = VP_BP;   else vp_s = VP_SYNC;
                            VP_BP:   if (v_s == ZERO)         vp_s = VP_ACT;  else vp_s = VP_BP;
                            default: vp_s = VP_ACT;
                        endcase
                    end else begin
                        h_s = h_r + ONE;
                    end
                    case (hp_r)
                        HP_ACT:  if (h_s == H_FP_START)   hp_s = HP_FP;   else hp_s = HP_ACT;
                        HP_FP:   if (h_s == H_SYNC_START) hp_s = HP_SYNC; else hp_s = HP_FP;
                        HP_SYNC: if (h_s == H_BP_START)   hp_s = HP_BP;   else hp_s = HP_SYNC;
                        HP_BP:   if (h_s == ZERO)         hp_s = HP_ACT;  else hp_s = HP_BP;
                        default: hp_s = HP_ACT;
                    endcase
                    line_start_s  = (h_s == ZERO);
                    frame_start_s = (h_s == ZERO) && (v_s == ZERO);
                end
                default: begin
                    top_s = ST_IDLE;
                end
            endcase
        end else begin
            // Hold everything; strobes fall back to 0 via the defaults.
            top_s = top_r;
        end

        // IDLE sits in the ACT phases but is not a visible position.
        hsync_s    = (hp_s != HP_SYNC);
        vsync_s    = (vp_s != VP_SYNC);
        video_on_s = (top_s == ST_RUN) && (hp_s == HP_ACT) && (vp_s == VP_ACT);
        if (video_on_s) begin
            x_s = h_s;
            y_s = v_s;
        end else begin
            x_s = ZERO;
            y_s = ZERO;
        end
    end

    // State and registered-output update; reset has priority over en.
    always_ff @(posedge clk) begin
        if (rst) begin
            top_r       <= ST_IDLE;
            hp_r        <= HP_ACT;
            vp_r        <= VP_ACT;
            h_r         <= ZERO;
            v_r         <= ZERO;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            video_on    <= 1'b0;
            x           <= ZERO;
            y           <= ZERO;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            top_r       <= top_s;
            hp_r        <= hp_s;
            vp_r        <= vp_s;
            h_r         <= h_s;
            v_r         <= v_s;
            hsync       <= hsync_s;
            vsync       <= vsync_s;
            video_on    <= video_on_s;
            x           <= x_s;
            y           <= y_s;
            line_start  <= line_start_s;
            frame_start <= frame_start_s;
        end
    end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_ctrl
//   Scoreboard bench. The driver applies rst/en each clock, steps a raster
//   position model and pushes the expected registered outputs into a queue;
//   a monitor on the falling edge pops and compares. The vertical geometry is
//   shrunk (60 lines) so a whole frame fits in a short run; the horizontal
//   geometry is the standard 800-pixel line.
// ---------------------------------------------------------------------------
module tb_vga_timing_ctrl;

    localparam int N   = 11;
    localparam int HA  = 640;
    localparam int HFP = 16;
    localparam int HS  = 96;
    localparam int HB  = 48;
    localparam int VA  = 48;
    localparam int VFP = 4;
    localparam int VS  = 2;
    localparam int VB  = 6;
    localparam int HT  = HA + HFP + HS + HB;   // 800
    localparam int VT  = VA + VFP + VS + VB;   // 60

    typedef struct packed {
        logic         hs;
        logic         vs;
        logic         vo;
        logic [N-1:0] x;
        logic [N-1:0] y;
        logic         ls;
        logic         fs;
    } obs_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en  = 1'b0;
    logic         hsync, vsync, video_on, line_start, frame_start;
    logic [N-1:0] x, y;

    int n_vec = 0;
    int n_err = 0;

    obs_t exp_q[$];

    // Reference position model
    bit m_run = 1'b0;
    int m_h   = 0;
    int m_v   = 0;
    bit m_ls  = 1'b0;
    bit m_fs  = 1'b0;

    vga_timing_ctrl #(
        .N(N), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VB)
    ) dut (
        .clk(clk), .rst(rst), .en(en),
        .hsync(hsync), .vsync(vsync), .video_on(video_on),
        .x(x), .y(y),
        .line_start(line_start), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", nm, act, req);
        end
    endtask

    function automatic obs_t model_out();
        obs_t o;
        o.vo = m_run && (m_h < HA) && (m_v < VA);
        o.hs = !(m_run && (m_h >= HA + HFP) && (m_h < HA + HFP + HS));
        o.vs = !(m_run && (m_v >= VA + VFP) && (m_v < VA + VFP + VS));
        o.x  = o.vo ? N'(m_h) : {N{1'b0}};
        o.y  = o.vo ? N'(m_v) : {N{1'b0}};
        o.ls = m_ls;
        o.fs = m_fs;
        return o;
    endfunction

    task automatic model_step(input logic r, input logic e);
        if (r) begin
            m_run = 1'b0; m_h = 0; m_v = 0; m_ls = 1'b0; m_fs = 1'b0;
        end else if (e) begin
            if (!m_run) begin
                m_run = 1'b1; m_h = 0; m_v = 0; m_ls = 1'b1; m_fs = 1'b1;
            end else begin
                if (m_h == HT - 1) begin
                    m_h = 0;
                    m_v = (m_v == VT - 1) ? 0 : m_v + 1;
                end else begin
                    m_h = m_h + 1;
                end
                m_ls = (m_h == 0);
                m_fs = (m_h == 0) && (m_v == 0);
            end
        end else begin
            m_ls = 1'b0; m_fs = 1'b0;
        end
    endtask

    // One clock: apply inputs, step the model, queue the expectation.
    // Returns #1 after the edge with the new DUT outputs settled.
    task automatic tick(input logic r, input logic e);
        rst = r;
        en  = e;
        model_step(r, e);
        @(posedge clk);
        exp_q.push_back(model_out());
        #1;
    endtask

    // Monitor: compare the DUT outputs against the queued expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            obs_t e, g;
            e = exp_q.pop_front();
            g.hs = hsync; g.vs = vsync; g.vo = video_on; g.x = x; g.y = y;
            g.ls = line_start; g.fs = frame_start;
            n_vec++;
            if (g !== e) begin
                n_err++;
                $display("FAIL outputs @%0t: got hs=%b vs=%b vo=%b x=%0d y=%0d ls=%b fs=%b, required hs=%b vs=%b vo=%b x=%0d y=%0d ls=%b fs=%b",
                         $time, g.hs, g.vs, g.vo, g.x, g.y, g.ls, g.fs,
                         e.hs, e.vs, e.vo, e.x, e.y, e.ls, e.fs);
            end
        end
    end

    initial begin
        int hs_low, vs_low, last_fs, first_ls, guard;
        bit hs_done, vs_done, fp_done, lp_done;

        @(posedge clk);
        #1;
        // Reset, then idle with en low: reset values.
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0);
        for (int i = 0; i < 2; i++) tick(1'b0, 1'b0);

        // Continuous en for a full frame plus a few ticks; measure widths.
        hs_low = 0; vs_low = 0; last_fs = -1;
        hs_done = 1'b0; vs_done = 1'b0; fp_done = 1'b0;
        for (int i = 0; i < HT * VT + 10; i++) begin
            tick(1'b0, 1'b1);
            if (i == 1) check("second_tick_x", int'(x), 1);
            if (hsync === 1'b0) hs_low++;
            else if (hs_low != 0) begin
                if (!hs_done) check("hsync_low_width", hs_low, HS);
                hs_done = 1'b1; hs_low = 0;
            end
            if (vsync === 1'b0) vs_low++;
            else if (vs_low != 0) begin
                if (!vs_done) check("vsync_low_width", vs_low, VS * HT);
                vs_done = 1'b1; vs_low = 0;
            end
            if (frame_start === 1'b1) begin
                if (last_fs >= 0 && !fp_done) begin
                    check("frame_period", i - last_fs, HT * VT);
                    fp_done = 1'b1;
                end
                last_fs = i;
            end
        end
        check("hsync_seen", int'(hs_done), 1);
        check("vsync_seen", int'(vs_done), 1);
        check("frame_period_seen", int'(fp_done), 1);

        // Run to (100,5), then hold en low for 10 clocks.
        guard = 0;
        while (!(m_h == 100 && m_v == 5) && guard < 10000) begin
            tick(1'b0, 1'b1);
            guard++;
        end
        check("reach_100_5", int'(m_h == 100 && m_v == 5), 1);
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b0);
        check("hold_x", int'(x), 100);
        check("hold_y", int'(y), 5);

        // en toggling every other clock: line period doubles.
        first_ls = -1; lp_done = 1'b0;
        for (int c = 0; c < 8000 && !lp_done; c++) begin
            tick(1'b0, (c % 2) == 1);
            if (line_start === 1'b1) begin
                if (first_ls >= 0) begin
                    check("toggle_line_period", c - first_ls, 2 * HT);
                    lp_done = 1'b1;
                end else begin
                    first_ls = c;
                end
            end
        end
        check("toggle_line_period_seen", int'(lp_done), 1);

        // Run to (300,20) and reset with en high on the same edge.
        guard = 0;
        while (!(m_h == 300 && m_v == 20) && guard < 30000) begin
            tick(1'b0, 1'b1);
            guard++;
        end
        check("reach_300_20", int'(m_h == 300 && m_v == 20), 1);
        tick(1'b1, 1'b1);
        check("rst_wins_video_on", int'(video_on), 0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);
        check("restart_frame_start", int'(frame_start), 1);
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b1);

        en = 1'b0;
        guard = 0;
        while (exp_q.size() > 0 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        check("queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
